// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and framebuffer geometry
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_SCALE     = 4;
  localparam int DEF_PIX_WIDTH = 8;

  // Geometry the framebuffer memory instance must agree with.
  localparam int DEF_FB_W    = DEF_H_ACTIVE / DEF_SCALE;
  localparam int DEF_FB_H    = DEF_V_ACTIVE / DEF_SCALE;
  localparam int DEF_FB_SIZE = DEF_FB_W * DEF_FB_H;
  localparam int DEF_FB_AW   = $clog2(DEF_FB_SIZE);

  function automatic bit scale_ok(int scale, int h_active, int v_active);
    return (scale > 0) && ((scale & (scale - 1)) == 0) &&
           (h_active % scale == 0) && (v_active % scale == 0);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - one raster axis: wrapping counter with active and sync flags
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  output logic [W-1:0] cnt,
  output logic         active,
  output logic         sync,
  output logic         last
);

  localparam logic [W-1:0] C_ACT  = W'(ACTIVE);
  localparam logic [W-1:0] C_SS   = W'(ACTIVE + FP);
  localparam logic [W-1:0] C_SE   = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] C_LAST = W'(TOTAL - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign last   = (cnt == C_LAST);
  assign active = (cnt < C_ACT);
  assign sync   = (cnt >= C_SS) && (cnt < C_SE);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA raster scan-out with SCALExSCALE pixel replication from a framebuffer
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   SCALE     = DEF_SCALE,
  parameter int   PIX_WIDTH = DEF_PIX_WIDTH,
  parameter int   FB_SIZE   = (H_ACTIVE / SCALE) * (V_ACTIVE / SCALE),
  localparam int  AW        = $clog2(FB_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_ce,
  output logic [AW-1:0]        fb_addr,
  input  logic [PIX_WIDTH-1:0] fb_data,
  output logic [PIX_WIDTH-1:0] rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SHIFT   = $clog2(SCALE);

  localparam logic [VW-1:0] V_MASK     = VW'(SCALE - 1);
  localparam logic [VW-1:0] V_LAST_ROW = VW'(V_ACTIVE - 1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(H_ACTIVE / SCALE);

  if (!scale_ok(SCALE, H_ACTIVE, V_ACTIVE)) begin : g_bad_scale
    $error("vga_scanout: SCALE must be a power of two dividing H_ACTIVE and V_ACTIVE");
  end

  logic [HW-1:0] h_cnt, h_shift;
  logic [VW-1:0] v_cnt;
  logic          h_act, h_sync, h_last;
  logic          v_act, v_sync, v_last;
  logic          v_ce;
  logic [AW-1:0] row_base;
  logic          de_s1, hs_s1, vs_s1, fs_s1;

  assign v_ce    = pix_ce & h_last;
  assign h_shift = h_cnt >> SHIFT;

  vga_timing_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .ce(pix_ce),
    .cnt(h_cnt), .active(h_act), .sync(h_sync), .last(h_last)
  );

  vga_timing_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .ce(v_ce),
    .cnt(v_cnt), .active(v_act), .sync(v_sync), .last(v_last)
  );

  // Row base tracks fb_y*(H_ACTIVE/SCALE); it stops at the last visible row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
    end else if (v_ce) begin
      if (v_last) begin
        row_base <= '0;
      end else if (((v_cnt & V_MASK) == V_MASK) && (v_cnt < V_LAST_ROW)) begin
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  // Stage 1 drives the memory address; stage 2 captures the returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr     <= '0;
      de_s1       <= 1'b0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
      fs_s1       <= 1'b0;
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      fb_addr     <= (h_act && v_act) ? row_base + AW'(h_shift) : '0;
      de_s1       <= h_act && v_act;
      hs_s1       <= h_sync;
      vs_s1       <= v_sync;
      fs_s1       <= (h_cnt == '0) && (v_cnt == '0);
      rgb         <= de_s1 ? fb_data : '0;
      de          <= de_s1;
      hsync       <= hs_s1 ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_s1 ? SYNC_POL : ~SYNC_POL;
      frame_start <= fs_s1;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout on a reduced raster geometry
module tb_vga_scanout;

  localparam int HA = 64, HFP = 8, HS = 12, HBP = 12;
  localparam int VA = 32, VFP = 3, VS = 2, VBP = 5;
  localparam int SC = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW = HA / SC;
  localparam int FBS = FBW * (VA / SC);
  localparam int AW = $clog2(FBS);

  typedef struct packed {
    logic [AW-1:0] fb_addr;
    logic [7:0]    rgb;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          frame_start;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_ce = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data, rgb;
  logic          hsync, vsync, de, frame_start;
  logic [7:0]    mem [FBS];

  int n_ce = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  assign fb_data = mem[fb_addr];

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .SCALE(SC), .PIX_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .fb_addr(fb_addr), .fb_data(fb_data), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  function automatic obs_t observed();
    return {fb_addr, rgb, hsync, vsync, de, frame_start};
  endfunction

  // Expected outputs after n pix_ce edges since reset release.
  function automatic obs_t expect_at(int n);
    obs_t e;
    int p, h, v;
    e = '0;
    e.hsync = 1'b1;
    e.vsync = 1'b1;
    if (n >= 1) begin
      p = (n - 1) % FRAME; h = p % HT; v = p / HT;
      if (h < HA && v < VA) e.fb_addr = AW'((v / SC) * FBW + h / SC);
    end
    if (n >= 2) begin
      p = (n - 2) % FRAME; h = p % HT; v = p / HT;
      e.de = (h < HA) && (v < VA);
      e.rgb = e.de ? mem[(v / SC) * FBW + h / SC] : 8'h00;
      e.hsync = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vsync = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.frame_start = (p == 0);
    end
    return e;
  endfunction

  task automatic step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    cyc++;
    if (ce && rst_n) n_ce++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < FBS; i++) mem[i] = 8'(i);
    rst_n = 1'b0;
    repeat (3) step(1'b1);
    n_checks++;
    if (observed() !== expect_at(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", observed(), expect_at(0));
    end
  endtask

  task automatic test_first_pixels();
    int fall_h, low_cnt;
    fall_h = -1;
    low_cnt = 0;
    rst_n = 1'b1;
    n_ce = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      step(1'b1);
      n_checks++;
      if (observed() !== expect_at(n_ce)) begin
        n_fail++;
        $display("FAIL first_pixels n=%0d: got %h expected %h", n_ce, observed(), expect_at(n_ce));
      end
      if (n_ce >= 2 && n_ce <= 9) begin
        n_checks++;
        if (rgb !== 8'((n_ce - 2) / 4) || de !== 1'b1) begin
          n_fail++;
          $display("FAIL replicate n=%0d: rgb=%0d de=%b expected rgb=%0d de=1", n_ce, rgb, de, (n_ce - 2) / 4);
        end
      end
      if (n_ce == 2 || n_ce == 3) begin
        n_checks++;
        if (frame_start !== (n_ce == 2)) begin
          n_fail++;
          $display("FAIL frame_start_pulse n=%0d: got %b expected %b", n_ce, frame_start, n_ce == 2);
        end
      end
      if (n_ce >= 2 && n_ce < HT + 2) begin
        if (!hsync) low_cnt++;
        if (!hsync && fall_h < 0) fall_h = n_ce - 2;
      end
    end
    n_checks++;
    if (fall_h != HA + HFP || low_cnt != HS) begin
      n_fail++;
      $display("FAIL hsync_window: start=%0d len=%0d expected start=%0d len=%0d", fall_h, low_cnt, HA + HFP, HS);
    end
  endtask

  task automatic test_address();
    int targets [2];
    int want [2];
    int k;
    targets[0] = 9 * HT + 5;             want[0] = 2 * FBW + 1;
    targets[1] = (VA - 1) * HT + HA - 1; want[1] = FBS - 1;
    for (int t = 0; t < 2; t++) begin
      k = 0;
      while (((n_ce - 1) % FRAME) != targets[t] && k < 2 * FRAME) begin
        step(1'b1);
        k++;
        n_checks++;
        if (observed() !== expect_at(n_ce)) begin
          n_fail++;
          $display("FAIL address_scan n=%0d: got %h expected %h", n_ce, observed(), expect_at(n_ce));
        end
      end
      n_checks++;
      if (k >= 2 * FRAME || fb_addr !== AW'(want[t])) begin
        n_fail++;
        $display("FAIL address_point %0d: fb_addr=%0d expected %0d (steps %0d)", t, fb_addr, want[t], k);
      end
    end
  endtask

  task automatic test_frame();
    int fs_cyc [$];
    int vs_fall, vs_len, vs_line;
    logic prev_vs;
    vs_fall = -1; vs_len = 0; vs_line = -1;
    prev_vs = vsync;
    for (int i = 0; i < 2 * FRAME + HT; i++) begin
      step(1'b1);
      n_checks++;
      if (observed() !== expect_at(n_ce)) begin
        n_fail++;
        $display("FAIL frame_scan n=%0d: got %h expected %h", n_ce, observed(), expect_at(n_ce));
      end
      if (frame_start) fs_cyc.push_back(cyc);
      if (prev_vs && !vsync && vs_fall < 0) begin
        vs_fall = cyc;
        vs_line = ((n_ce - 2) % FRAME) / HT;
      end
      if (vs_fall >= 0 && !vsync && (cyc - vs_fall) < FRAME / 2) vs_len++;
      prev_vs = vsync;
    end
    n_checks++;
    if (fs_cyc.size() < 2 || fs_cyc[1] - fs_cyc[0] != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: pulses=%0d period=%0d expected %0d", fs_cyc.size(),
               (fs_cyc.size() >= 2) ? fs_cyc[1] - fs_cyc[0] : -1, FRAME);
    end
    n_checks++;
    if (vs_line != VA + VFP || vs_len != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_window: line=%0d len=%0d expected line=%0d len=%0d", vs_line, vs_len, VA + VFP, VS * HT);
    end
  endtask

  task automatic test_blanking();
    int de_cnt;
    de_cnt = 0;
    for (int i = 0; i < FBS; i++) mem[i] = 8'hFF;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1);
      if (de) de_cnt++;
      n_checks++;
      if (rgb !== (de ? 8'hFF : 8'h00) || fb_addr !== expect_at(n_ce).fb_addr) begin
        n_fail++;
        $display("FAIL blanking n=%0d: rgb=%h de=%b fb_addr=%0d expected fb_addr=%0d",
                 n_ce, rgb, de, fb_addr, expect_at(n_ce).fb_addr);
      end
    end
    n_checks++;
    if (de_cnt != HA * VA) begin
      n_fail++;
      $display("FAIL de_count: got %0d expected %0d", de_cnt, HA * VA);
    end
  endtask

  task automatic test_ce_toggle();
    int fs_rise [$];
    obs_t prev;
    logic prev_fs;
    prev = observed();
    prev_fs = frame_start;
    for (int i = 0; i < 4 * FRAME + 8; i++) begin
      step(i % 2 == 0);
      n_checks++;
      if (i % 2 == 1) begin
        if (observed() !== prev) begin
          n_fail++;
          $display("FAIL ce_hold cyc=%0d: got %h expected %h", cyc, observed(), prev);
        end
      end else if (observed() !== expect_at(n_ce)) begin
        n_fail++;
        $display("FAIL ce_toggle n=%0d: got %h expected %h", n_ce, observed(), expect_at(n_ce));
      end
      if (frame_start && !prev_fs) fs_rise.push_back(cyc);
      prev = observed();
      prev_fs = frame_start;
    end
    n_checks++;
    if (fs_rise.size() < 2 || fs_rise[1] - fs_rise[0] != 2 * FRAME) begin
      n_fail++;
      $display("FAIL ce_frame_period: pulses=%0d period=%0d expected %0d", fs_rise.size(),
               (fs_rise.size() >= 2) ? fs_rise[1] - fs_rise[0] : -1, 2 * FRAME);
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < FBS; i++) mem[i] = 8'($urandom);
    step(1'b1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0);
      n_checks++;
      if (observed() !== expect_at(n_ce)) begin
        n_fail++;
        $display("FAIL random_ce n=%0d: got %h expected %h", n_ce, observed(), expect_at(n_ce));
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    while ((n_ce % FRAME) != 12 * HT + 20 && k < 2 * FRAME) begin
      step(1'b1);
      k++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (k >= 2 * FRAME || observed() !== expect_at(0)) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected %h (steps %0d)", observed(), expect_at(0), k);
    end
    repeat (3) step(1'b1);
    n_checks++;
    if (observed() !== expect_at(0)) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %h expected %h", observed(), expect_at(0));
    end
    #2;
    rst_n = 1'b1;
    n_ce = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      step(1'b1);
      n_checks++;
      if (observed() !== expect_at(n_ce)) begin
        n_fail++;
        $display("FAIL restart n=%0d: got %h expected %h", n_ce, observed(), expect_at(n_ce));
      end
      if (n_ce == 2) begin
        n_checks++;
        if (frame_start !== 1'b1 || fb_addr !== AW'(0)) begin
          n_fail++;
          $display("FAIL restart_frame_start: frame_start=%b fb_addr=%0d expected 1 and 0", frame_start, fb_addr);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_pixels();
    test_address();
    test_frame();
    test_blanking();
    test_ce_toggle();
    test_random_ce();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Raster scan-out stage that sits directly downstream of the framebuffer memory. It generates VGA horizontal/vertical timing and drives the framebuffer read address, which the memory resolves combinationally. It registers the returned pixel word onto the RGB output, aligned with sync and data-enable. Each framebuffer pixel is replicated SCALE×SCALE on screen.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- SCALE, 4, pixel replication factor; power of two; must divide H_ACTIVE and V_ACTIVE
- PIX_WIDTH, 8, framebuffer word width
- FB_SIZE, (H_ACTIVE/SCALE)*(V_ACTIVE/SCALE), framebuffer depth
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel clock enable; all state advances only when high
- fb_addr  out  $clog2(FB_SIZE)  framebuffer read address (registered)
- fb_data  in  PIX_WIDTH  framebuffer read data, combinational from fb_addr
- rgb  out  PIX_WIDTH  pixel output
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable (active video)
- frame_start  out  1  one-pix_ce pulse aligned with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- h_cnt counts 0..H_TOTAL-1 on pix_ce and wraps to 0. v_cnt increments when h_cnt wraps and wraps to 0 after V_TOTAL-1.
- h_cnt=0 is the first active pixel. Horizontal active when h_cnt<H_ACTIVE. Hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). The vertical axis uses the same rule.
- fb_x = h_cnt/SCALE and fb_y = v_cnt/SCALE. Compute by shift only.
- fb_addr = fb_y*(H_ACTIVE/SCALE)+fb_x. Build it from a row-base accumulator: add H_ACTIVE/SCALE when v_cnt crosses a SCALE boundary, clear at frame wrap. No multiplier.
- Outside active video, fb_addr is driven 0.
- rgb = fb_data when the delayed de=1, else 0.
- Sync levels: the asserted level equals SYNC_POL; the inactive level is ~SYNC_POL.
- pix_ce low: counters, pipeline registers and all outputs hold.
- Reset (async assert, any time, including mid-frame):
  - h_cnt=v_cnt=0 and row base 0.
  - fb_addr=0, rgb=0, de=0, frame_start=0.
  - hsync=vsync=~SYNC_POL.
  - The first pix_ce after release processes pixel (0,0).

## Timing
- Stage 0: counters at pix_ce t.
- Stage 1: fb_addr, de/hsync/vsync/frame_start stage-1 copies registered at pix_ce t+1. fb_data is valid in this same cycle.
- Stage 2: rgb, de, hsync, vsync and frame_start registered at pix_ce t+2.
- Latency: 2 pix_ce from counter position to outputs; all outputs are mutually aligned.
- The framebuffer write port is independent; a write to the address being read may show old or new data, with no tearing protection.
- Output line period = H_TOTAL pix_ce; frame period = H_TOTAL*V_TOTAL pix_ce.

## Structure
- Shared package vga_pkg holds:
  - default timing constants;
  - H_TOTAL/V_TOTAL localparam derivations;
  - the framebuffer geometry constants shared with the memory instance.
- Sub-module vga_timing_counter holds one axis: counter with wrap, active flag and sync flag; parameters ACTIVE/FP/SYNC/BP; inputs clk, rst_n, ce. It is instantiated for H (ce=pix_ce) and V (ce=pix_ce & h_wrap).
- Elaboration asserts SCALE is a power of two and divides both active sizes.

## Test plan
- Reset release, pix_ce=1 constant, mem[i]=i[7:0]:
  - 2 cycles later, de=1, rgb=0x00 and frame_start=1 for one cycle;
  - rgb increments every 4 cycles (0,0,0,0,1,…);
  - hsync goes low at output h=656 for 96 cycles.
- Address check: counter at (h=5, v=9) -> fb_addr=2*160+1=321 one cycle later; (639,479) -> 19199.
- Frame length: frame_start pulses exactly every 420000 cycles; vsync is low for 1600 cycles starting at line 490.
- Blanking: mem filled with 0xFF; rgb=0 whenever de=0 (h≥640 or v≥480); fb_addr=0 in blanking.
- pix_ce toggling every other cycle: all outputs change only on pix_ce cycles; the frame takes 840000 cycles.
- rst_n pulled low at (h=300, v=200) between clock edges:
  - outputs are immediately at reset values: rgb=0, de=0, hsync=vsync=1;
  - after release, scan restarts at (0,0) with frame_start 2 pix_ce later.
